// File: rtl/flag_ctx_if.sv
// Control/status bundle between the control unit and the flag register.
// The control unit drives the strobes; the flag register reports live and stack state.
interface flag_ctx_if #(
    parameter int FLAG_LEN  = 8,
    parameter int ALU_FLAGS = 4,
    parameter int LVL_W     = 3,
    parameter int BSEL_W    = 3
);
    logic                 read_data;
    logic                 write_data;
    logic                 set_flag_alu;
    logic [ALU_FLAGS-1:0] alu_mask;
    logic [ALU_FLAGS-1:0] alu_flags_in;
    logic                 bit_op;
    logic [BSEL_W-1:0]    bit_sel;
    logic                 bit_val;
    logic                 push;
    logic                 pop;
    logic                 err_clr;
    logic [FLAG_LEN-1:0]  flag_out;
    logic [LVL_W-1:0]     stk_level;
    logic                 stk_full;
    logic                 stk_empty;
    logic                 stk_err;

    modport master (
        output read_data, write_data, set_flag_alu, alu_mask, alu_flags_in,
        output bit_op, bit_sel, bit_val, push, pop, err_clr,
        input  flag_out, stk_level, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  read_data, write_data, set_flag_alu, alu_mask, alu_flags_in,
        input  bit_op, bit_sel, bit_val, push, pop, err_clr,
        output flag_out, stk_level, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/flag_ctx_reg.sv
// Processor flag register with bus load/drive, masked ALU update, bit ops
// and a small LIFO used to save/restore flags across interrupts.
module flag_ctx_reg #(
    parameter int FLAG_LEN  = 8,
    parameter int ALU_FLAGS = 4,
    parameter int DEPTH     = 4,
    parameter int LVL_W     = 3,
    parameter int BSEL_W    = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    inout  wire  [FLAG_LEN-1:0] flag,
    flag_ctx_if.slave           ctl
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_LEN-1:0] live;
    logic [FLAG_LEN-1:0] live_nx;
    logic [FLAG_LEN-1:0] stk [DEPTH];
    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    level_m1;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic                full;
    logic                empty;
    logic                both;
    logic                push_ok;
    logic                pop_ok;
    logic                err_set;
    logic                sel_pop;
    logic                sel_rd;
    logic                sel_bit;
    logic                sel_alu;
    logic                bit_in_range;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign both     = ctl.push & ctl.pop;
    assign push_ok  = ctl.push & ~ctl.pop & ~full;
    assign pop_ok   = ctl.pop & ~ctl.push & ~empty;
    assign err_set  = both
                    | (ctl.push & ~ctl.pop & full)
                    | (ctl.pop & ~ctl.push & empty);
    assign level_m1 = level - LVL_W'(1);
    assign wr_idx   = level[IDX_W-1:0];
    assign rd_idx   = level_m1[IDX_W-1:0];

    assign bit_in_range = (int'(ctl.bit_sel) < FLAG_LEN);

    // Mutually exclusive source selects encode the fixed priority.
    assign sel_pop = pop_ok;
    assign sel_rd  = ~sel_pop & ctl.read_data & ~ctl.write_data;
    assign sel_bit = ~sel_pop & ~sel_rd & ctl.bit_op;
    assign sel_alu = ~sel_pop & ~sel_rd & ~ctl.bit_op & ctl.set_flag_alu;

    always_comb begin
        live_nx = live;
        unique case (1'b1)
            sel_pop: live_nx = stk[rd_idx];
            sel_rd:  live_nx = flag;
            sel_bit: begin
                if (bit_in_range)
                    live_nx[ctl.bit_sel] = ctl.bit_val;
            end
            sel_alu: begin
                live_nx[ALU_FLAGS-1:0] =
                    (live[ALU_FLAGS-1:0] & ~ctl.alu_mask)
                  | (ctl.alu_flags_in & ctl.alu_mask);
            end
            default: live_nx = live;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            live       <= '0;
            level      <= '0;
            ctl.stk_err <= 1'b0;
        end else begin
            live <= live_nx;
            if (push_ok)
                level <= level + LVL_W'(1);
            else if (pop_ok)
                level <= level_m1;
            if (err_set)
                ctl.stk_err <= 1'b1;
            else if (ctl.err_clr)
                ctl.stk_err <= 1'b0;
        end
    end

    // Stack storage is never read before a push, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (push_ok)
            stk[wr_idx] <= live;
    end

    assign flag = ctl.write_data ? live : {FLAG_LEN{1'bz}};

    assign ctl.flag_out  = live;
    assign ctl.stk_level = level;
    assign ctl.stk_full  = full;
    assign ctl.stk_empty = empty;
endmodule

// File: doc/flag_ctx_reg.md
Name: flag_ctx_reg

Overview:
- Parametrised processor flag register with a hardware context stack for interrupt entry and return.
- Holds FLAG_LEN flag bits. Supports load and drive over the shared bidirectional data bus, masked ALU flag updates, and single-bit set/clear by instruction.
- Adds a DEPTH-entry LIFO so the control unit can save flags (push) and restore them (pop) without bus traffic.
- Sits between the ALU, the control unit and the internal data bus.

Parameters:
- FLAG_LEN, 8: width of the flag register and of the bus.
- ALU_FLAGS, 4: number of low-order bits the ALU may update. Bit0=CF, bit1=ZF, bit2=SF, bit3=OF. Must satisfy ALU_FLAGS <= FLAG_LEN.
- DEPTH, 4: number of context stack entries. Must be >= 1.
- LVL_W, 3: width of the stack level count. Must satisfy 2**LVL_W > DEPTH.
- BSEL_W, 3: width of the bit selector. Must satisfy 2**BSEL_W >= FLAG_LEN.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- read_data  input  1  load the live register from the flag bus.
- write_data  input  1  drive the live register onto the flag bus.
- set_flag_alu  input  1  apply the masked ALU flag update.
- alu_mask  input  ALU_FLAGS  per-bit enable for the ALU update.
- alu_flags_in  input  ALU_FLAGS  new ALU flag values.
- bit_op  input  1  single-bit write strobe.
- bit_sel  input  BSEL_W  index of the bit written by bit_op.
- bit_val  input  1  value written by bit_op.
- push  input  1  save the live register to the stack.
- pop  input  1  restore the live register from the stack.
- err_clr  input  1  clear the sticky stk_err.
- flag  inout  FLAG_LEN  shared data bus.
- flag_out  output  FLAG_LEN  live register value.
- stk_level  output  LVL_W  number of occupied stack entries.
- stk_full  output  1  stk_level == DEPTH.
- stk_empty  output  1  stk_level == 0.
- stk_err  output  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (asynchronous, RESET low):
  - Live register = 0, stk_level = 0, stk_err = 0.
  - Stack contents are don't-care; no read may observe them before a push.
  - Resulting outputs: flag_out = 0, stk_empty = 1, stk_full = 0.
  - Reset asserted mid-operation aborts the operation; no partial update survives.
- Bus:
  - flag = live register while write_data = 1, otherwise high-Z. This is combinational; there is no latency.
  - While write_data = 1, read_data is ignored (no self-load).
- Live register next-state, in strict priority order, one source per cycle:
  1. Valid pop: load the top stack entry.
  2. read_data (and write_data = 0): load flag.
  3. bit_op: bit[bit_sel] = bit_val. If bit_sel >= FLAG_LEN the write is ignored; stk_err is not set.
  4. set_flag_alu: for each i < ALU_FLAGS, bit[i] = alu_mask[i] ? alu_flags_in[i] : bit[i]. Bits >= ALU_FLAGS are untouched.
  5. Otherwise hold.
- Latency:
  - All updates are visible on flag_out one cycle after the strobe edge.
  - ALU flags presented in cycle N appear on flag_out in cycle N+1.
- push (pop = 0):
  - If not full: write the pre-update live value into entry[stk_level], then stk_level+1.
  - Same-cycle read_data, bit_op or set_flag_alu still update the live register; the stack receives the old value.
  - If full: the push is ignored, stk_err = 1, the stack is unchanged, and the live register update still applies.
- pop (push = 0):
  - If not empty: live register = entry[stk_level-1], then stk_level-1. This overrides all other sources.
  - If empty: the pop is ignored, stk_err = 1, and lower-priority sources apply normally.
- push and pop in the same cycle:
  - Both are ignored, stk_err = 1, stk_level is unchanged, and lower-priority sources apply.
- stk_err:
  - Sticky; cleared by err_clr.
  - If err_clr coincides with a new error in the same cycle, the set wins.
- stk_full, stk_empty and stk_level are registered-state decodes with no extra latency.
- Level arithmetic never wraps; the over/underflow cases above guarantee 0 <= stk_level <= DEPTH.

Test Plan:
1. Reset, then read_data=1 with flag=8'hA5 for 1 cycle, then write_data=1 → bus shows 8'hA5, flag_out=8'hA5. With write_data=0 the bus is Z.
2. Live=8'hF0; set_flag_alu=1, alu_mask=4'b0011, alu_flags_in=4'b1101 → flag_out=8'hF1. Next: bit_op=1, bit_sel=7, bit_val=0 → 8'h71.
3. Push 8'h11, 8'h22, 8'h33, 8'h44 (DEPTH=4) → stk_full=1, stk_level=4. A 5th push gives stk_err=1 and level stays 4. Four pops restore 8'h44, 8'h33, 8'h22, 8'h11 on consecutive cycles, and stk_empty=1.
4. Live=8'h0F, level 0; push together with set_flag_alu, mask=4'hF, in=4'h0 → stack top=8'h0F, flag_out=8'h00. Pop with set_flag_alu high → flag_out=8'h0F (pop wins).
5. Pop when empty with read_data=1, flag=8'h5A → flag_out=8'h5A, stk_err=1. err_clr → stk_err=0. push+pop together at level 1 → stk_err=1, level stays 1.
6. Assert RESET low asynchronously mid-push sequence at level 2 → flag_out=0, stk_level=0, stk_err=0 immediately, without waiting for a CLK edge.
